// File: rtl/alu_seq_if.sv
// Request/response handshake bundle for the sequential ALU.
// The requester drives the master side and the ALU sits on the slave side.
interface alu_seq_if #(
  parameter int W = 16
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         err;

  modport master (
    output req_valid, a, b, op, rsp_ready,
    input  req_ready, rsp_valid, out, zero, err
  );

  modport slave (
    input  req_valid, a, b, op, rsp_ready,
    output req_ready, rsp_valid, out, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: logic ops finish in one EXEC cycle, shifts walk one bit per cycle,
// and the result is held in DONE until the consumer takes it.
module alu_seq #(
  parameter int W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   op_q;
  logic [W-1:0] acc_q;
  logic [3:0]   cnt_q;
  logic [W-1:0] out_q;
  logic         zero_q;
  logic         err_q;
  logic [W-1:0] res_d;

  // Final result as it will be registered when the shift counter runs out.
  always_comb begin
    res_d = '0;
    case (op_q)
      3'd0:    res_d = a_q + b_q;
      3'd1:    res_d = a_q & b_q;
      3'd2:    res_d = a_q | b_q;
      3'd3:    res_d = a_q ^ b_q;
      3'd4:    res_d = acc_q;
      3'd5:    res_d = acc_q;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'd0;
      acc_q   <= '0;
      cnt_q   <= 4'd0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            acc_q   <= bus.a;
            cnt_q   <= (bus.op == 3'd4 || bus.op == 3'd5) ? bus.b[3:0] : 4'd0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            acc_q <= (op_q == 3'd4) ? (acc_q << 1) : (acc_q >> 1);
            cnt_q <= cnt_q - 4'd1;
          end else begin
            out_q   <= res_d;
            zero_q  <= (res_d == '0);
            err_q   <= (op_q == 3'd6 || op_q == 3'd7);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random transactions against a plain-arithmetic model of the ALU,
// including backpressure, latency and asynchronous reset during a shift.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] m_out;
  logic        m_zero;
  logic        m_err;

  alu_seq_if #(.W(16)) bus ();

  alu_seq #(.W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_out(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return a << b[3:0];
      3'd5:    return a >> b[3:0];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input int hold);
    logic [15:0] eo;
    logic        ez;
    logic        ee;
    int          lat;
    int          cyc;
    eo  = ref_out(a, b, op);
    ez  = (eo == 16'h0000);
    ee  = (op >= 3'd6);
    lat = (op == 3'd4 || op == 3'd5) ? int'(b[3:0]) + 1 : 1;

    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    chk("out_hold_idle", {16'd0, bus.out}, {16'd0, m_out});

    bus.req_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.a  = 16'($urandom);
    bus.b  = 16'($urandom);
    bus.op = 3'($urandom);
    chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);

    cyc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 40) begin
      chk("out_hold_exec", {16'd0, bus.out}, {16'd0, m_out});
      @(posedge clk); #1; cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("out", {16'd0, bus.out}, {16'd0, eo});
    chk("zero", {31'd0, bus.zero}, {31'd0, ez});
    chk("err", {31'd0, bus.err}, {31'd0, ee});
    m_out  = eo;
    m_zero = ez;
    m_err  = ee;

    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.a  = 16'($urandom);
      bus.b  = 16'($urandom);
      bus.op = 3'($urandom);
      @(posedge clk); #1;
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_out", {16'd0, bus.out}, {16'd0, eo});
      chk("bp_zero", {31'd0, bus.zero}, {31'd0, ez});
      chk("bp_err", {31'd0, bus.err}, {31'd0, ee});
    end

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("release_zero_hold", {31'd0, bus.zero}, {31'd0, m_zero});
    chk("release_err_hold", {31'd0, bus.err}, {31'd0, m_err});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_out  = 16'h0000;
    m_zero = 1'b0;
    m_err  = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.a  = 16'h0000;
    bus.b  = 16'h0000;
    bus.op = 3'd0;

    // Reset values before any clock edge.
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_out", {16'd0, bus.out}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(16'h0001, 16'h0001, 3'd1, 0);
    run_op(16'hFFFF, 16'h0001, 3'd0, 0);
    run_op(16'h0001, 16'h000F, 3'd4, 0);
    run_op(16'h0004, 16'h0001, 3'd5, 10);
    run_op(16'h1234, 16'h5678, 3'd6, 2);
    run_op(16'hABCD, 16'hFFF0, 3'd4, 0);
    run_op(16'hA5A5, 16'h0F0F, 3'd3, 1);
    run_op(16'h8000, 16'h0007, 3'd7, 0);

    // Asynchronous reset five cycles into a long shift.
    bus.req_valid = 1'b1;
    bus.a  = 16'h0001;
    bus.b  = 16'h000F;
    bus.op = 3'd4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_out", {16'd0, bus.out}, 32'd0);
    chk("mid_rst_zero", {31'd0, bus.zero}, 32'd0);
    chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
    m_out  = 16'h0000;
    m_zero = 1'b0;
    m_err  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    run_op(16'h0003, 16'h0002, 3'd4, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(16'($urandom), 16'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: W, default 16, datapath width in bits.
REQ-002 Clk  input  1  the single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 ReqValid  input  1  requester presents a valid operation.
REQ-005 ReqReady  output  1  block can accept an operation.
REQ-006 InputA  input  W  operand A.
REQ-007 InputB  input  W  operand B; bits [3:0] are the shift amount for shift ops.
REQ-008 OP  input  3  opcode.
REQ-009 RspValid  output  1  result valid.
REQ-010 RspReady  input  1  consumer accepts the result.
REQ-011 Out  output  W  result.
REQ-012 Zero  output  1  Out == 0.
REQ-013 Err  output  1  illegal opcode was issued.

Function
REQ-014 Opcodes: 0 ADD (A+B mod 2^W, carry discarded); 1 AND; 2 OR; 3 XOR; 4 SHL logical by B[3:0]; 5 SHR logical by B[3:0], zero fill; 6, 7 illegal.
REQ-015 States IDLE, EXEC, DONE; encoding is free.
REQ-016 ReqReady = 1 only in IDLE; RspValid = 1 only in DONE; both are registered-state decodes.
REQ-017 Accept: in IDLE on an edge with ReqValid=1 -> capture InputA, InputB, OP; load shift counter = B[3:0] for OP 4/5, else 0; go to EXEC.
REQ-018 No accept in EXEC or DONE; inputs are ignored there.
REQ-019 EXEC, counter != 0: shift accumulator one bit in the op direction, decrement counter, stay in EXEC.
REQ-020 EXEC, counter == 0: register final Out (shift accumulator for 4/5, combinational result for 0-3, 0 for 6/7), Zero = (final Out == 0), Err = (OP in {6,7}); go to DONE.
REQ-021 Latency: RspValid rises N+1 cycles after the accept edge, N = shift amount for OP 4/5, else 0; maximum 16 cycles.
REQ-022 Shift amount 0 -> Out = A, latency 1.
REQ-023 DONE: Out, Zero, Err held stable while RspReady = 0 (backpressure of any length).
REQ-024 DONE with RspReady = 1 at an edge -> IDLE; ReqReady rises in the following cycle (no same-cycle response/request overlap).
REQ-025 Out, Zero, Err hold their last values in IDLE and EXEC until overwritten by the next completion.
REQ-026 Illegal opcode: latency 1, Out = 0, Zero = 1, Err = 1.

Reset
REQ-027 Reset asserted -> immediately, without waiting for Clk: state IDLE, ReqReady = 1, RspValid = 0, Out = 0, Zero = 0, Err = 0, counter = 0.
REQ-028 Reset during EXEC or DONE abandons the operation; no response is produced for it.
REQ-029 First accept is possible on the first rising edge after Reset deasserts.

Verification
REQ-030 A=0x0001, B=0x0001, OP=1 -> RspValid 1 cycle after accept, Out=0x0001, Zero=0, Err=0.
REQ-031 A=0xFFFF, B=0x0001, OP=0 -> Out=0x0000, Zero=1 (carry dropped).
REQ-032 A=0x0001, B=0x000F, OP=4 -> RspValid exactly 16 cycles after accept, Out=0x8000; A=0x0004, B=0x0001, OP=5 -> Out=0x0002 after 2 cycles.
REQ-033 Completed result with RspReady held 0 for 10 cycles -> Out/Zero/Err and RspValid unchanged, ReqReady=0 throughout, new ReqValid ignored; RspReady=1 -> IDLE next cycle.
REQ-034 OP=6 with any operands -> Out=0x0000, Zero=1, Err=1 after 1 cycle.
REQ-035 Reset pulsed mid-shift (OP=4, B=0x000F, 5 cycles in) -> outputs at reset values asynchronously, no RspValid, next op after release completes correctly.
